spi_serializer: RTL and testbench

- Parallel-to-serial SPI master transmitter, write-only (no MISO).
- A rising edge on ld latches the low FRAME_BITS of Data_Register and shifts them out MSB first, in SPI mode 0 (CPOL=0, CPHA=0).
- CS is driven low for the whole frame.
- Sits between a register/control block and an external SPI slave, e.g. a 24-bit DAC or synthesiser.

---
 rtl/spi_serializer.sv | 166 ++++++++++++++++
 tb/tb_spi_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_serializer.sv
`default_nettype none
// ============================================================================
// Module   : spi_serializer
// Brief    : Write-only SPI mode-0 master; a rising edge on ld shifts out the
//            low FRAME_BITS of Data_Register with CS held low for the frame.
//            Optional macro SPI_SERIALIZER_LSB_FIRST_EN selects LSB-first order.
// Revision : 1.0  initial release
// ============================================================================
module spi_serializer #(
    parameter int FRAME_BITS = 24,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Data_Register,
    input  logic        ld,
    output logic        DataBit,
    output logic        SPI_clk,
    output logic        CS
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic                  ld_q,     ld_d;
    logic                  cs_q,     cs_d;
    logic                  sclk_q,   sclk_d;
    logic                  dbit_q,   dbit_d;
    logic [FRAME_BITS-1:0] shreg_q,  shreg_d;
    logic [DIV_W-1:0]      div_q,    div_d;
    logic [BIT_W-1:0]      bits_q,   bits_d;
    logic [GAP_W-1:0]      gap_q,    gap_d;

    logic                  start;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  load_bit;
    logic [FRAME_BITS-1:0] load_rest;
    logic                  next_bit;
    logic [FRAME_BITS-1:0] shift_rest;
    logic                  unused_data;

    assign start       = ld & ~ld_q;
    assign frame_word  = Data_Register[FRAME_BITS-1:0];
    // Bits above FRAME_BITS-1 are deliberately ignored.
    assign unused_data = ^Data_Register;

    // The first bit goes straight to DataBit; the shift register holds the rest.
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
    assign load_bit   = frame_word[0];
    assign load_rest  = frame_word >> 1;
    assign next_bit   = shreg_q[0];
    assign shift_rest = shreg_q >> 1;
`else
    assign load_bit   = frame_word[FRAME_BITS-1];
    assign load_rest  = frame_word << 1;
    assign next_bit   = shreg_q[FRAME_BITS-1];
    assign shift_rest = shreg_q << 1;
`endif

    always_comb begin
        state_d = state_q;
        ld_d    = ld;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        dbit_d  = dbit_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        bits_d  = bits_q;
        gap_d   = gap_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    dbit_d  = load_bit;
                    shreg_d = load_rest;
                    div_d   = '0;
                    bits_d  = '0;
                end
            end

            SHIFT: begin
                if (div_q == C_DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        bits_d = bits_q + BIT_W'(1);
                    end else if (bits_q == C_BIT_LAST) begin
                        // Falling edge after the last bit closes the frame.
                        state_d = GAP;
                        cs_d    = 1'b1;
                        sclk_d  = 1'b0;
                        dbit_d  = 1'b0;
                        gap_d   = '0;
                    end else begin
                        sclk_d  = 1'b0;
                        dbit_d  = next_bit;
                        shreg_d = shift_rest;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                dbit_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ld_q    <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            dbit_q  <= 1'b0;
            shreg_q <= '0;
            div_q   <= '0;
            bits_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            dbit_q  <= dbit_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            gap_q   <= gap_d;
        end
    end

    assign CS      = cs_q;
    assign SPI_clk = sclk_q;
    assign DataBit = dbit_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_serializer.sv
`default_nettype none
// Testbench for spi_serializer: directed frames with a bit scoreboard popped
// at every SPI_clk rising edge, plus frame length and idle-output monitors.
module tb_spi_serializer;

    localparam int FRAME_BITS = 24;
    localparam int CLK_DIV    = 4;
    localparam int CS_GAP     = 4;
    localparam int CS_LOW     = 2 * CLK_DIV * FRAME_BITS;

    logic        clk;
    logic        rst;
    logic [31:0] Data_Register;
    logic        ld;
    logic        DataBit;
    logic        SPI_clk;
    logic        CS;

    spi_serializer #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV),
        .CS_GAP     (CS_GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Data_Register (Data_Register),
        .ld            (ld),
        .DataBit       (DataBit),
        .SPI_clk       (SPI_clk),
        .CS            (CS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   exp_q[$];
    bit   mon_en        = 0;
    bit   abort_pending = 0;
    logic cs_prev       = 1'b1;
    logic sclk_prev     = 1'b0;
    int   cs_cnt        = 0;
    int   rise_cnt      = 0;
    int   phase_cnt     = 0;
    int   cs_falls      = 0;
    int   frames_done   = 0;
    int   exp_falls     = 0;
    int   exp_frames    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Monitor: sample outputs on the falling clk edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (CS === 1'b0 && cs_prev === 1'b1) begin
                cs_falls++;
                cs_cnt    = 0;
                rise_cnt  = 0;
                phase_cnt = 0;
            end
            if (CS === 1'b0) cs_cnt++;
            if (SPI_clk !== sclk_prev) begin
                if (!abort_pending) check("sclk_phase_len", phase_cnt, CLK_DIV);
                phase_cnt = 0;
            end
            phase_cnt++;
            if (SPI_clk === 1'b1 && sclk_prev === 1'b0) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_sclk_rise", 32'd1, 32'd0);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    check("databit_at_rise", {31'd0, DataBit}, {31'd0, e});
                end
            end
            if (CS === 1'b1 && cs_prev === 1'b0) begin
                if (abort_pending) begin
                    abort_pending = 0;
                end else begin
                    frames_done++;
                    check("cs_low_cycles", cs_cnt, CS_LOW);
                    check("rises_per_frame", rise_cnt, FRAME_BITS);
                end
            end
            if (CS === 1'b1) check("idle_outputs", {30'd0, SPI_clk, DataBit}, 32'd0);
            cs_prev   = CS;
            sclk_prev = SPI_clk;
        end
    end

    task automatic push_frame(input logic [31:0] d);
        for (int i = 0; i < FRAME_BITS; i++) begin
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
            exp_q.push_back(d[i]);
`else
            exp_q.push_back(d[FRAME_BITS-1-i]);
`endif
        end
        exp_falls++;
        exp_frames++;
    endtask

    task automatic send(input logic [31:0] d, input int hold);
        @(negedge clk);
        Data_Register = d;
        ld            = 1'b1;
        push_frame(d);
        repeat (hold) @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (frames_done < exp_frames && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, frames_done, exp_frames);
        repeat (CS_GAP + 2) @(negedge clk);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        check({tag, "_cs_falls"}, cs_falls, exp_falls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        ld            = 1'b0;
        Data_Register = 32'd0;

        // Reset held for 3 cycles while ld toggles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld = ~ld;
            check("reset_cs", {31'd0, CS}, 32'd1);
            check("reset_sclk", {31'd0, SPI_clk}, 32'd0);
            check("reset_databit", {31'd0, DataBit}, 32'd0);
        end
        mon_en = 1;
        @(negedge clk);
        rst = 1'b0;
        ld  = 1'b0;
        repeat (20) @(negedge clk);
        check("no_frame_after_reset", cs_falls, 32'd0);

        // Basic frame with ld held high for several cycles.
        send(32'h009E6D55, 7);
        wait_done("frame1");

        // Second frame after a long idle period.
        repeat (1250) @(negedge clk);
        send(32'h0080F0FE, 2);
        wait_done("frame2");
        check("frame2_cs_after", {31'd0, CS}, 32'd1);
        check("frame2_databit_after", {31'd0, DataBit}, 32'd0);

        // Busy rejection: new edge mid-frame is dropped.
        send(32'h00AAAAAA, 2);
        repeat (48) @(negedge clk);
        Data_Register = 32'h00555555;
        ld            = 1'b1;
        repeat (3) @(negedge clk);
        ld = 1'b0;
        wait_done("busy_frame");
        repeat (300) @(negedge clk);
        check("busy_no_second_frame", cs_falls, exp_falls);

        // Edge arriving after the gap is accepted.
        send(32'h00555555, 2);
        wait_done("after_gap_frame");

        // Data_Register changes mid-frame do not disturb the frame.
        send(32'h00000000, 2);
        repeat (30) @(negedge clk);
        Data_Register = 32'h00FFFFFF;
        wait_done("stability_frame");

        // Reset in the middle of a frame.
        send(32'h00C3A5F0, 2);
        begin
            int k;
            k = 0;
            while (rise_cnt < 10 && k < 1000) begin
                @(negedge clk);
                k++;
            end
            check("reach_bit10", {31'd0, rise_cnt >= 10}, 32'd1);
        end
        abort_pending = 1;
        exp_frames--;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs", {31'd0, CS}, 32'd1);
        check("abort_sclk", {31'd0, SPI_clk}, 32'd0);
        check("abort_databit", {31'd0, DataBit}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("no_resume_after_reset", cs_falls, exp_falls);
        send(32'h00C3A5F0, 2);
        wait_done("after_reset_frame");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
